eth_rmii_rx_fcs: RTL and testbench

Inbound RMII receiver for the motor-controller Ethernet path. It samples the PHY receive dibits, finds the preamble and SFD, and assembles bytes. It checks the CRC-32 and delivers frame bytes with the 4 FCS bytes stripped. It sits between the upstream PHY pins and the chain/UDP parsers, and produces the byte stream that feeds the outbound chain transmitter, plus a per-frame good/bad verdict.

---
 rtl/eth_rmii_rx_fcs.sv | 94 +++++++++
 tb/tb_eth_rmii_rx_fcs.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/eth_rmii_rx_fcs.sv
// eth_rmii_rx_fcs: RMII receiver with preamble/SFD hunt, byte assembly, CRC-32 check and FCS stripping
module eth_rmii_rx_fcs #(
  parameter int MIN_LEN = 64
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic [1:0]  phy_rxd,
  input  logic        phy_rxdv,
  output logic [7:0]  rxd,
  output logic        rxdv,
  output logic        rxe,
  output logic        fcs_ok,
  output logic [10:0] rx_len
);
  typedef enum logic [1:0] {IDLE, HUNT, DATA, DISCARD} state_t;
  state_t      state, state_nx;
  logic        seen01;
  logic [1:0]  dcnt;
  logic [5:0]  sh;
  logic [7:0]  nb;
  logic [31:0] dl;
  logic [31:0] crc;
  logic [10:0] cnt;
  assign nb = {phy_rxd, sh};
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  // state register
  always_ff @(posedge clk_50 or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  // next-state logic: preamble hunt accepts 00/01 filler, needs a 01 before the SFD's closing 11
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = phy_rxdv ? HUNT : IDLE;
      HUNT:    state_nx = !phy_rxdv ? IDLE :
                          (phy_rxd == 2'b00 || phy_rxd == 2'b01) ? HUNT :
                          (phy_rxd == 2'b11 && seen01) ? DATA : DISCARD;
      DATA:    state_nx = phy_rxdv ? DATA : IDLE;
      DISCARD: state_nx = phy_rxdv ? DISCARD : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // datapath: byte assembly, 4-byte delay line that hides the FCS, CRC and end-of-frame verdict
  always_ff @(posedge clk_50 or posedge rst)
    if (rst) begin
      seen01 <= 1'b0;
      dcnt   <= '0;
      sh     <= '0;
      dl     <= '0;
      crc    <= 32'hFFFFFFFF;
      cnt    <= '0;
      rxd    <= '0;
      rxdv   <= 1'b0;
      rxe    <= 1'b0;
      fcs_ok <= 1'b0;
      rx_len <= '0;
    end else begin
      rxdv   <= 1'b0;
      rxe    <= 1'b0;
      fcs_ok <= 1'b0;
      if (state == IDLE) seen01 <= 1'b0;
      if (state == HUNT && phy_rxdv && phy_rxd == 2'b01) seen01 <= 1'b1;
      if (state_nx == DATA && state == HUNT) begin
        dcnt <= '0;
        sh   <= '0;
        dl   <= '0;
        crc  <= 32'hFFFFFFFF;
        cnt  <= '0;
      end
      if (state == DATA && phy_rxdv) begin
        sh   <= nb[7:2];
        dcnt <= dcnt + 2'd1;
        if (dcnt == 2'd3) begin
          dl  <= {dl[23:0], nb};
          crc <= crc_byte(crc, nb);
          cnt <= (cnt == 11'd2047) ? cnt : cnt + 11'd1;
          if (cnt >= 11'd4) begin
            rxd  <= dl[31:24];
            rxdv <= 1'b1;
          end
        end
      end
      if (state == DATA && !phy_rxdv) begin
        rxe    <= 1'b1;
        rx_len <= (cnt >= 11'd4) ? cnt - 11'd4 : '0;
        fcs_ok <= crc == 32'hDEBB20E3 && dcnt == 2'd0 && cnt >= 11'(MIN_LEN) && cnt != 11'd2047;
      end
    end
endmodule

// File: tb/tb_eth_rmii_rx_fcs.sv
// tb_eth_rmii_rx_fcs: scoreboard bench for the RMII receiver with directed frames
module tb_eth_rmii_rx_fcs;
  logic        clk_50 = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  phy_rxd = 2'b00;
  logic        phy_rxdv = 1'b0;
  logic [7:0]  rxd;
  logic        rxdv;
  logic        rxe;
  logic        fcs_ok;
  logic [10:0] rx_len;
  eth_rmii_rx_fcs #(.MIN_LEN(64)) dut (
    .clk_50(clk_50), .rst(rst), .phy_rxd(phy_rxd), .phy_rxdv(phy_rxdv),
    .rxd(rxd), .rxdv(rxdv), .rxe(rxe), .fcs_ok(fcs_ok), .rx_len(rx_len)
  );
  always #10 clk_50 = ~clk_50;
  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;
  typedef struct {logic [7:0] d; int c;} bexp_t;
  typedef struct {logic ok; logic [10:0] len; int c;} eexp_t;
  bexp_t bq[$];
  eexp_t eq[$];
  logic done = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [1:0] fc [4] = '{2'b00, 2'b10, 2'b01, 2'b11};

  function automatic logic [31:0] crc32(input logic [7:0] b[$]);
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    foreach (b[n])
      for (int i = 0; i < 8; i++) r = (r[0] ^ b[n][i]) ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  task automatic build(input int n, output logic [7:0] b[$]);
    logic [31:0] c;
    b = {};
    for (int i = 0; i < n; i++) b.push_back(8'(i));
    c = ~crc32(b);
    for (int k = 0; k < 4; k++) b.push_back(c[8*k +: 8]);
  endtask

  task automatic drive(input logic dv, input logic [1:0] d);
    phy_rxdv = dv;
    phy_rxd  = d;
    @(posedge clk_50);
    #1;
  endtask

  task automatic send(input logic [7:0] b[$], input int extra, input logic ok, input int rst_at);
    logic [7:0] cur;
    for (int p = 0; p < 8; p++) begin
      cur = (p < 7) ? 8'h55 : 8'hD5;
      for (int k = 0; k < 4; k++) drive(1'b1, cur[2*k +: 2]);
    end
    for (int n = 0; n < b.size(); n++)
      for (int k = 0; k < 4; k++) begin
        if (n == rst_at && k == 2) begin
          #4 rst = 1'b1;
          phy_rxdv = 1'b0;
          phy_rxd  = 2'b00;
          repeat (3) @(posedge clk_50);
          #1 rst = 1'b0;
          repeat (8) drive(1'b0, 2'b00);
          return;
        end
        cur = b[n];
        if (k == 3 && n >= 4) bq.push_back('{b[n-4], cyc + 1});
        drive(1'b1, cur[2*k +: 2]);
      end
    repeat (extra) drive(1'b1, 2'b10);
    eq.push_back('{ok, 11'(b.size() - 4), cyc + 1});
    drive(1'b0, 2'b00);
    repeat (12) drive(1'b0, 2'b00);
  endtask

  initial begin
    logic [7:0] f[$];
    repeat (3) @(posedge clk_50);
    #1 rst = 1'b0;
    repeat (5) drive(1'b0, 2'b00);
    build(60, f); send(f, 0, 1'b1, -1);
    build(60, f); f[63] ^= 8'h01; send(f, 0, 1'b0, -1);
    build(60, f); send(f, 2, 1'b0, -1);
    build(36, f); send(f, 0, 1'b0, -1);
    for (int i = 0; i < 20; i++) drive(1'b1, fc[i % 4]);
    repeat (6) drive(1'b0, 2'b00);
    build(60, f); send(f, 0, 1'b1, -1);
    build(60, f); send(f, 0, 1'b1, 20);
    build(100, f); send(f, 0, 1'b1, -1);
    done = 1'b1;
  end

  initial begin
    bexp_t be;
    eexp_t ee;
    forever begin
      @(negedge clk_50);
      if (rst) begin
        n_tests++;
        if ({rxd, rxdv, rxe, fcs_ok, rx_len} != '0) begin
          n_fail++;
          $display("FAIL reset_outputs: got rxd=%h rxdv=%b rxe=%b fcs_ok=%b rx_len=%0d, want all 0",
                   rxd, rxdv, rxe, fcs_ok, rx_len);
        end
      end else begin
        if (rxdv) begin
          n_tests++;
          if (bq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_strobe: got rxd=%h at cycle %0d, want no strobe", rxd, cyc);
          end else begin
            be = bq.pop_front();
            if (rxd !== be.d || cyc != be.c) begin
              n_fail++;
              $display("FAIL byte: got %h at cycle %0d, want %h at cycle %0d", rxd, cyc, be.d, be.c);
            end
          end
        end
        if (rxe) begin
          n_tests++;
          if (eq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rxe: got rxe at cycle %0d, want none", cyc);
          end else begin
            ee = eq.pop_front();
            if (fcs_ok !== ee.ok || rx_len !== ee.len || cyc != ee.c || rxdv) begin
              n_fail++;
              $display("FAIL frame_end: got ok=%b len=%0d cycle=%0d rxdv=%b, want ok=%b len=%0d cycle=%0d rxdv=0",
                       fcs_ok, rx_len, cyc, rxdv, ee.ok, ee.len, ee.c);
            end
          end
        end
        if (fcs_ok && !rxe) begin
          n_tests++;
          n_fail++;
          $display("FAIL fcs_ok_outside_rxe: got fcs_ok=1 at cycle %0d, want 0", cyc);
        end
      end
      if (done || cyc > 30000) begin
        if (!done) begin
          n_fail++;
          $display("FAIL timeout: got cycle %0d, want stimulus complete", cyc);
        end
        n_tests++;
        if (bq.size() != 0 || eq.size() != 0) begin
          n_fail++;
          $display("FAIL missing_outputs: got %0d bytes and %0d ends outstanding, want 0 and 0",
                   bq.size(), eq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end
endmodule
